// File: rtl/fanout_fork_buffer.sv
// Registered eager-fork stage: holds one token and broadcasts it to every active sink,
// tracking which sinks still owe an accept so each sees the token exactly once.
module fanout_fork_buffer #(
  parameter int unsigned DATA_WIDTH = 17,
  parameter int unsigned NUM_OUT    = 9,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [NUM_OUT-1:0]    cfg_en,
  input  logic [NUM_OUT-1:0]    cfg_sel,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [NUM_OUT-1:0]    out_valid,
  input  logic [NUM_OUT-1:0]    out_ready,
  output logic [CNT_WIDTH-1:0]  tok_count
);

  logic                  buf_valid_q, buf_valid_d;
  logic [DATA_WIDTH-1:0] buf_data_q, buf_data_d;
  logic [NUM_OUT-1:0]    pending_q, pending_d;
  logic [CNT_WIDTH-1:0]  tok_count_q, tok_count_d;

  logic [NUM_OUT-1:0] acc;
  logic [NUM_OUT-1:0] active_mask;
  logic               retire;
  logic               load;

  assign out_valid   = {NUM_OUT{buf_valid_q}} & pending_q;
  assign out_data    = buf_data_q;
  assign tok_count   = tok_count_q;
  assign acc         = out_valid & out_ready;
  assign active_mask = cfg_en & cfg_sel;

  // Entry completes when every sink still owed the token accepts this cycle.
  assign retire   = buf_valid_q & ((pending_q & ~acc) == '0);
  assign in_ready = ~flush & (~buf_valid_q | retire);
  assign load     = in_valid & in_ready;

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    pending_d   = pending_q;
    tok_count_d = tok_count_q;
    if (flush) begin
      buf_valid_d = 1'b0;
      pending_d   = '0;
    end else if (load) begin
      buf_data_d  = in_data;
      pending_d   = active_mask;
      // A token with no active sink is counted but never held.
      buf_valid_d = |active_mask;
      tok_count_d = tok_count_q + 1'b1;
    end else if (retire) begin
      buf_valid_d = 1'b0;
      pending_d   = '0;
    end else begin
      pending_d   = pending_q & ~acc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid_q <= 1'b0;
      buf_data_q  <= '0;
      pending_q   <= '0;
      tok_count_q <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
      pending_q   <= pending_d;
      tok_count_q <= tok_count_d;
    end
  end

endmodule
